mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive data grants while an instruction request is pending.
REQ-002 CLK  input  1  system clock, rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 iREN  input  1  icache read request.
REQ-005 iaddr  input  32  icache word address.
REQ-006 iwait  output  1  low for exactly the cycle iload is valid.
REQ-007 iload  output  32  instruction data.
REQ-008 dREN  input  1  dcache read request.
REQ-009 dWEN  input  1  dcache write request.
REQ-010 daddr  input  32  dcache word address.
REQ-011 dstore  input  32  dcache write data.
REQ-012 dwait  output  1  low for exactly the cycle the data access completes.
REQ-013 dload  output  32  load data.
REQ-014 ramREN  output  1  RAM read enable.
REQ-015 ramWEN  output  1  RAM write enable.
REQ-016 ramaddr  output  32  RAM address.
REQ-017 ramstore  output  32  RAM write data.
REQ-018 ramload  input  32  RAM read data.
REQ-019 ramstate  input  2  RAM status (FREE, BUSY, ACCESS, ERROR).

Function
REQ-020 FSM states IDLE, IFETCH, DLOAD, DSTORE; grant registered, so a request seen in IDLE enters its grant state on the next edge.
REQ-021 IDLE arbitration: dWEN -> DSTORE, else dREN -> DLOAD, else iREN -> IFETCH; exception: starve count == STARVE_LIMIT with iREN high -> IFETCH.
REQ-022 dREN and dWEN both high: treated as store.
REQ-023 IFETCH: ramREN=1, ramaddr=iaddr; DLOAD: ramREN=1, ramaddr=daddr; DSTORE: ramWEN=1, ramaddr=daddr, ramstore=dstore.
REQ-024 IDLE: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
REQ-025 In a grant state with ramstate==ACCESS: the owner's wait goes low combinationally that cycle; FSM returns to IDLE next edge.
REQ-026 iwait/dwait are high in every other cycle; the non-owner's wait is always high.
REQ-027 iload=ramload and dload=ramload, passthrough; valid only while the matching wait is low.
REQ-028 Minimum latency: request at cycle 0, wait low at cycle 1 if RAM returns ACCESS immediately.
REQ-029 Back-to-back requests: one IDLE cycle is inserted between grants.
REQ-030 ramstate BUSY or FREE in a grant state: hold state and outputs.
REQ-031 ramstate ERROR in a grant state: wait stays high; return to IDLE and re-arbitrate.
REQ-032 Owner request deasserts in a grant state before ACCESS: abort and return to IDLE; no wait-low pulse.
REQ-033 Starve counter width is clog2(STARVE_LIMIT+1).
REQ-034 Starve counter increments, saturating, on a data grant when iREN is high.
REQ-035 Starve counter clears on an IFETCH grant, or on a data grant when iREN is low.

Reset
REQ-036 nRST low forces IDLE and starve counter 0 immediately, including mid-transaction.
REQ-037 During reset: ramREN=0, ramWEN=0, iwait=1, dwait=1.

Structure
REQ-038 ramstate encoding (FREE=0, BUSY=1, ACCESS=2, ERROR=3) and word_t (32-bit) come from the shared cpu types package.
REQ-039 The arbiter FSM state enum is local to the module.
REQ-040 Single module, no sub-modules; instantiated beside icache/dcache between the cache wrapper and RAM.

Verification
REQ-041 dREN=1, daddr=0x40, RAM ACCESS on the first grant cycle, ramload=0xDEADBEEF -> ramREN=1 at cycle 1, dwait=0 and dload=0xDEADBEEF at cycle 1 only.
REQ-042 iREN, dREN and dWEN all high at cycle 0, dstore=0x1234 -> DSTORE granted first with ramWEN=1 and ramstore=0x1234; DLOAD next; then IFETCH.
REQ-043 iREN held high with continuous dREN, STARVE_LIMIT=4 -> 4 data grants, then an IFETCH grant with iwait low once, then the counter reads 0.
REQ-044 DLOAD with ramstate BUSY for 3 cycles then ACCESS -> dwait high for 3 cycles, low for 1, FSM in IDLE next.
REQ-045 nRST asserted mid-DSTORE -> ramWEN=0 and dwait=1 asynchronously; after release, FSM in IDLE with no spurious wait-low pulse.
REQ-046 ERROR returned in IFETCH, then iREN dropped -> iwait never low, FSM in IDLE, ramREN=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared CPU types for the memory arbiter slice.
// RAM status encoding and the machine word type.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signals of the memory arbiter.
// master = arbiter view, slave = caches/RAM view.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;

  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    input  iREN, iaddr,
    output iwait, iload,
    input  dREN, dWEN, daddr, dstore,
    output dwait, dload,
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    output iREN, iaddr,
    input  iwait, iload,
    output dREN, dWEN, daddr, dstore,
    input  dwait, dload,
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache.
// Data has priority; a starve counter forces an ifetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.master bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DLOAD  = 2'd2,
    DSTORE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [CW-1:0] data_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Count a data grant only while an ifetch is waiting.
  always_comb begin
    data_cnt = '0;
    if (bus.iREN)
      data_cnt = (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
  end

  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (starve_q == LIMIT && bus.iREN) begin
          state_d  = IFETCH;
          starve_d = '0;
        end else if (bus.dWEN) begin
          state_d  = DSTORE;
          starve_d = data_cnt;
        end else if (bus.dREN) begin
          state_d  = DLOAD;
          starve_d = data_cnt;
        end else if (bus.iREN) begin
          state_d  = IFETCH;
          starve_d = '0;
        end
      end
      IFETCH: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        if (!bus.iREN) begin
          state_d = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          bus.iwait = 1'b0;
          state_d   = IDLE;
        end else if (bus.ramstate == ERROR) begin
          state_d = IDLE;
        end
      end
      DLOAD: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.daddr;
        if (!bus.dREN) begin
          state_d = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          bus.dwait = 1'b0;
          state_d   = IDLE;
        end else if (bus.ramstate == ERROR) begin
          state_d = IDLE;
        end
      end
      DSTORE: begin
        bus.ramWEN   = 1'b1;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (!bus.dWEN) begin
          state_d = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          bus.dwait = 1'b0;
          state_d   = IDLE;
        end else if (bus.ramstate == ERROR) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Each task drives one scenario and checks inline.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic CLK;
  logic nRST;
  int   passed;
  int   total;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.master)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    idle_inputs();
    bus.iREN = 1'b1;
    bus.dREN = 1'b1;
    tick();
    tick();
    total++; if (bus.ramREN !== 1'b0) $display("FAIL rst_ramREN got %b want 0", bus.ramREN); else passed++;
    total++; if (bus.ramWEN !== 1'b0) $display("FAIL rst_ramWEN got %b want 0", bus.ramWEN); else passed++;
    total++; if (bus.iwait !== 1'b1) $display("FAIL rst_iwait got %b want 1", bus.iwait); else passed++;
    total++; if (bus.dwait !== 1'b1) $display("FAIL rst_dwait got %b want 1", bus.dwait); else passed++;
    total++; if (dut.starve_q !== 3'd0) $display("FAIL rst_starve got %0d want 0", dut.starve_q); else passed++;
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_min_latency();
    bus.dREN     = 1'b1;
    bus.daddr    = 32'h40;
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hDEADBEEF;
    #1;
    total++; if (bus.ramREN !== 1'b0) $display("FAIL lat_c0_ramREN got %b want 0", bus.ramREN); else passed++;
    total++; if (bus.dwait !== 1'b1) $display("FAIL lat_c0_dwait got %b want 1", bus.dwait); else passed++;
    tick();
    total++; if (bus.ramREN !== 1'b1) $display("FAIL lat_c1_ramREN got %b want 1", bus.ramREN); else passed++;
    total++; if (bus.ramaddr !== 32'h40) $display("FAIL lat_c1_addr got %h want 00000040", bus.ramaddr); else passed++;
    total++; if (bus.dwait !== 1'b0) $display("FAIL lat_c1_dwait got %b want 0", bus.dwait); else passed++;
    total++; if (bus.dload !== 32'hDEADBEEF) $display("FAIL lat_c1_dload got %h want deadbeef", bus.dload); else passed++;
    total++; if (bus.iwait !== 1'b1) $display("FAIL lat_c1_iwait got %b want 1", bus.iwait); else passed++;
    bus.dREN = 1'b0;
    tick();
    total++; if (bus.dwait !== 1'b1) $display("FAIL lat_c2_dwait got %b want 1", bus.dwait); else passed++;
    total++; if (bus.ramREN !== 1'b0) $display("FAIL lat_c2_ramREN got %b want 0", bus.ramREN); else passed++;
  endtask

  task automatic test_priority();
    bus.iREN     = 1'b1;
    bus.dREN     = 1'b1;
    bus.dWEN     = 1'b1;
    bus.iaddr    = 32'h100;
    bus.daddr    = 32'h200;
    bus.dstore   = 32'h1234;
    bus.ramstate = ACCESS;
    tick();
    total++; if (bus.ramWEN !== 1'b1) $display("FAIL pri_st_ramWEN got %b want 1", bus.ramWEN); else passed++;
    total++; if (bus.ramREN !== 1'b0) $display("FAIL pri_st_ramREN got %b want 0", bus.ramREN); else passed++;
    total++; if (bus.ramstore !== 32'h1234) $display("FAIL pri_st_store got %h want 00001234", bus.ramstore); else passed++;
    total++; if (bus.dwait !== 1'b0) $display("FAIL pri_st_dwait got %b want 0", bus.dwait); else passed++;
    tick();
    total++; if (bus.ramWEN !== 1'b0) $display("FAIL pri_gap1_ramWEN got %b want 0", bus.ramWEN); else passed++;
    total++; if (bus.ramaddr !== 32'h0) $display("FAIL pri_gap1_addr got %h want 00000000", bus.ramaddr); else passed++;
    bus.dWEN = 1'b0;
    tick();
    total++; if (bus.ramREN !== 1'b1) $display("FAIL pri_ld_ramREN got %b want 1", bus.ramREN); else passed++;
    total++; if (bus.ramaddr !== 32'h200) $display("FAIL pri_ld_addr got %h want 00000200", bus.ramaddr); else passed++;
    total++; if (bus.dwait !== 1'b0) $display("FAIL pri_ld_dwait got %b want 0", bus.dwait); else passed++;
    tick();
    total++; if (bus.ramREN !== 1'b0) $display("FAIL pri_gap2_ramREN got %b want 0", bus.ramREN); else passed++;
    bus.dREN = 1'b0;
    tick();
    total++; if (bus.ramaddr !== 32'h100) $display("FAIL pri_if_addr got %h want 00000100", bus.ramaddr); else passed++;
    total++; if (bus.iwait !== 1'b0) $display("FAIL pri_if_iwait got %b want 0", bus.iwait); else passed++;
    total++; if (bus.dwait !== 1'b1) $display("FAIL pri_if_dwait got %b want 1", bus.dwait); else passed++;
    bus.iREN = 1'b0;
    tick();
  endtask

  task automatic test_starve();
    bus.iREN     = 1'b1;
    bus.dREN     = 1'b1;
    bus.iaddr    = 32'hA0;
    bus.daddr    = 32'hB0;
    bus.ramstate = ACCESS;
    for (int g = 0; g < 4; g++) begin
      tick();
      total++; if (bus.ramaddr !== 32'hB0) $display("FAIL stv_d%0d_addr got %h want 000000b0", g, bus.ramaddr); else passed++;
      total++; if (bus.iwait !== 1'b1) $display("FAIL stv_d%0d_iwait got %b want 1", g, bus.iwait); else passed++;
      tick();
    end
    total++; if (dut.starve_q !== 3'd4) $display("FAIL stv_cnt4 got %0d want 4", dut.starve_q); else passed++;
    tick();
    total++; if (bus.ramaddr !== 32'hA0) $display("FAIL stv_if_addr got %h want 000000a0", bus.ramaddr); else passed++;
    total++; if (bus.iwait !== 1'b0) $display("FAIL stv_if_iwait got %b want 0", bus.iwait); else passed++;
    total++; if (bus.dwait !== 1'b1) $display("FAIL stv_if_dwait got %b want 1", bus.dwait); else passed++;
    total++; if (dut.starve_q !== 3'd0) $display("FAIL stv_cnt0 got %0d want 0", dut.starve_q); else passed++;
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    tick();
  endtask

  task automatic test_busy();
    bus.dREN     = 1'b1;
    bus.daddr    = 32'hC0;
    bus.ramstate = BUSY;
    bus.ramload  = 32'h55AA55AA;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (bus.dwait !== 1'b1) $display("FAIL busy_c%0d_dwait got %b want 1", c, bus.dwait); else passed++;
      total++; if (bus.ramREN !== 1'b1) $display("FAIL busy_c%0d_ramREN got %b want 1", c, bus.ramREN); else passed++;
    end
    bus.ramstate = ACCESS;
    #1;
    total++; if (bus.dwait !== 1'b0) $display("FAIL busy_acc_dwait got %b want 0", bus.dwait); else passed++;
    total++; if (bus.dload !== 32'h55AA55AA) $display("FAIL busy_acc_dload got %h want 55aa55aa", bus.dload); else passed++;
    bus.dREN = 1'b0;
    tick();
    total++; if (bus.ramREN !== 1'b0) $display("FAIL busy_idle_ramREN got %b want 0", bus.ramREN); else passed++;
    total++; if (bus.dwait !== 1'b1) $display("FAIL busy_idle_dwait got %b want 1", bus.dwait); else passed++;
  endtask

  task automatic test_reset_mid();
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h10;
    bus.dWEN     = 1'b1;
    bus.daddr    = 32'hD0;
    bus.dstore   = 32'h77;
    bus.ramstate = BUSY;
    tick();
    total++; if (bus.ramWEN !== 1'b1) $display("FAIL rmid_pre_ramWEN got %b want 1", bus.ramWEN); else passed++;
    total++; if (dut.starve_q !== 3'd1) $display("FAIL rmid_pre_cnt got %0d want 1", dut.starve_q); else passed++;
    #2;
    nRST = 1'b0;
    #1;
    total++; if (bus.ramWEN !== 1'b0) $display("FAIL rmid_ramWEN got %b want 0", bus.ramWEN); else passed++;
    total++; if (bus.dwait !== 1'b1) $display("FAIL rmid_dwait got %b want 1", bus.dwait); else passed++;
    total++; if (dut.starve_q !== 3'd0) $display("FAIL rmid_cnt got %0d want 0", dut.starve_q); else passed++;
    bus.iREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.ramstate = ACCESS;
    tick();
    nRST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (bus.dwait !== 1'b1) $display("FAIL rmid_post%0d_dwait got %b want 1", c, bus.dwait); else passed++;
      total++; if (bus.ramWEN !== 1'b0) $display("FAIL rmid_post%0d_ramWEN got %b want 0", c, bus.ramWEN); else passed++;
    end
  endtask

  task automatic test_error_abort();
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h300;
    bus.ramstate = ERROR;
    tick();
    total++; if (bus.ramREN !== 1'b1) $display("FAIL err_ramREN got %b want 1", bus.ramREN); else passed++;
    total++; if (bus.iwait !== 1'b1) $display("FAIL err_iwait got %b want 1", bus.iwait); else passed++;
    bus.iREN = 1'b0;
    tick();
    total++; if (bus.ramREN !== 1'b0) $display("FAIL err_idle_ramREN got %b want 0", bus.ramREN); else passed++;
    total++; if (bus.iwait !== 1'b1) $display("FAIL err_idle_iwait got %b want 1", bus.iwait); else passed++;
    bus.dREN     = 1'b1;
    bus.daddr    = 32'h400;
    bus.ramstate = BUSY;
    tick();
    total++; if (bus.ramaddr !== 32'h400) $display("FAIL abt_addr got %h want 00000400", bus.ramaddr); else passed++;
    bus.dREN     = 1'b0;
    bus.ramstate = ACCESS;
    #1;
    total++; if (bus.dwait !== 1'b1) $display("FAIL abt_dwait got %b want 1", bus.dwait); else passed++;
    tick();
    total++; if (bus.ramREN !== 1'b0) $display("FAIL abt_idle_ramREN got %b want 0", bus.ramREN); else passed++;
    total++; if (bus.dwait !== 1'b1) $display("FAIL abt_idle_dwait got %b want 1", bus.dwait); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_min_latency();
    test_priority();
    test_starve();
    test_busy();
    test_reset_mid();
    test_error_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
